// File: rtl/dsm_pkg.sv
// Shared definitions for the DSM H-bridge driver: ternary code values and leg state encoding.
package dsm_pkg;

    localparam logic [1:0] PWM_ZERO = 2'b00;
    localparam logic [1:0] PWM_POS  = 2'b01;
    localparam logic [1:0] PWM_NEG  = 2'b11;
    localparam logic [1:0] PWM_INV  = 2'b10;

    typedef enum logic [1:0] {
        LEG_OFF     = 2'd0,
        LEG_DEAD    = 2'd1,
        LEG_LOW_ON  = 2'd2,
        LEG_HIGH_ON = 2'd3
    } leg_state_t;

endpackage

// File: rtl/dsm_leg_deadtime.sv
// One half-bridge leg: dead-time and minimum on-time sequencing between its high and low switch.
module dsm_leg_deadtime
    import dsm_pkg::*;
#(
    parameter int DEAD_CYCLES   = 4,
    parameter int MIN_ON_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic run,
    output logic hs,
    output logic ls,
    output logic dead
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LOAD  = CNT_W'(MIN_ON_CYCLES - 1);

    leg_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] mcnt, mcnt_next;
    logic             side_high;

    assign side_high = (state == LEG_HIGH_ON);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LEG_OFF;
            cnt   <= '0;
            mcnt  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            mcnt  <= mcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mcnt_next  = mcnt;
        // Loss of run beats every counter so a fault never waits out min-on.
        if (!run) begin
            state_next = LEG_OFF;
            cnt_next   = '0;
            mcnt_next  = '0;
        end else begin
            case (state)
                LEG_OFF: begin
                    state_next = LEG_DEAD;
                    cnt_next   = DEAD_LOAD;
                end
                LEG_DEAD: begin
                    if (cnt == '0) begin
                        state_next = req ? LEG_HIGH_ON : LEG_LOW_ON;
                        mcnt_next  = MIN_LOAD;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                LEG_LOW_ON, LEG_HIGH_ON: begin
                    // A differing request waits here until min-on has elapsed.
                    if ((req != side_high) && (mcnt == '0)) begin
                        state_next = LEG_DEAD;
                        cnt_next   = DEAD_LOAD;
                    end else if (mcnt != '0) begin
                        mcnt_next = mcnt - 1'b1;
                    end
                end
                default: state_next = LEG_OFF;
            endcase
        end
    end

    assign hs   = (state == LEG_HIGH_ON);
    assign ls   = (state == LEG_LOW_ON);
    assign dead = (state == LEG_OFF) || (state == LEG_DEAD);

endmodule

// File: rtl/dsm_bridge_driver.sv
// H-bridge gate driver for the DSM ternary output: input register, code decode, error flag, fault gating.
module dsm_bridge_driver
    import dsm_pkg::*;
#(
    parameter int DEAD_CYCLES   = 4,
    parameter int MIN_ON_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] pwm,
    input  logic       enable,
    input  logic       fault,
    input  logic       clr_err,
    output logic       hs_a,
    output logic       ls_a,
    output logic       hs_b,
    output logic       ls_b,
    output logic       dead_a,
    output logic       dead_b,
    output logic       err_invalid
);

    logic [1:0] pwm_q;
    logic       req_a, req_b, run;
    logic       leg_hs_a, leg_ls_a, leg_hs_b, leg_ls_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q       <= PWM_ZERO;
            err_invalid <= 1'b0;
        end else begin
            pwm_q <= pwm;
            // A fresh invalid sample outranks a simultaneous clear.
            if (pwm_q == PWM_INV) begin
                err_invalid <= 1'b1;
            end else if (clr_err) begin
                err_invalid <= 1'b0;
            end
        end
    end

    // Invalid code decodes to neither request, i.e. both legs freewheel low.
    assign req_a = (pwm_q == PWM_POS);
    assign req_b = (pwm_q == PWM_NEG);
    assign run   = enable && !fault;

    dsm_leg_deadtime #(
        .DEAD_CYCLES  (DEAD_CYCLES),
        .MIN_ON_CYCLES(MIN_ON_CYCLES),
        .CNT_W        (CNT_W)
    ) u_leg_a (
        .clock(clock),
        .reset(reset),
        .req  (req_a),
        .run  (run),
        .hs   (leg_hs_a),
        .ls   (leg_ls_a),
        .dead (dead_a)
    );

    dsm_leg_deadtime #(
        .DEAD_CYCLES  (DEAD_CYCLES),
        .MIN_ON_CYCLES(MIN_ON_CYCLES),
        .CNT_W        (CNT_W)
    ) u_leg_b (
        .clock(clock),
        .reset(reset),
        .req  (req_b),
        .run  (run),
        .hs   (leg_hs_b),
        .ls   (leg_ls_b),
        .dead (dead_b)
    );

    // Combinational fault path so gates drop without waiting for a clock edge.
    assign hs_a = leg_hs_a && !fault;
    assign ls_a = leg_ls_a && !fault;
    assign hs_b = leg_hs_b && !fault;
    assign ls_b = leg_ls_b && !fault;

endmodule

// File: tb/tb_dsm_bridge_driver.sv
// Bench for dsm_bridge_driver: vector table through an expected queue, hand sequences, random safety monitor.
module tb_dsm_bridge_driver;

    localparam int DEAD_CYCLES   = 4;
    localparam int MIN_ON_CYCLES = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] pwm = 2'b00;
    logic       enable = 1'b1;
    logic       fault = 1'b0;
    logic       clr_err = 1'b0;
    logic       hs_a, ls_a, hs_b, ls_b, dead_a, dead_b, err_invalid;

    int checks = 0;
    int errors = 0;

    // exp = {hs_a, ls_a, hs_b, ls_b, dead_a, dead_b, err_invalid}
    typedef struct {
        logic       rst;
        logic       en;
        logic       flt;
        logic       clr;
        logic [1:0] code;
        logic [6:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];

    always #5 clock = ~clock;

    dsm_bridge_driver #(
        .DEAD_CYCLES  (DEAD_CYCLES),
        .MIN_ON_CYCLES(MIN_ON_CYCLES),
        .CNT_W        (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pwm        (pwm),
        .enable     (enable),
        .fault      (fault),
        .clr_err    (clr_err),
        .hs_a       (hs_a),
        .ls_a       (ls_a),
        .hs_b       (hs_b),
        .ls_b       (ls_b),
        .dead_a     (dead_a),
        .dead_b     (dead_b),
        .err_invalid(err_invalid)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic v(input logic rst, input logic en, input logic flt, input logic clr,
                     input logic [1:0] code, input logic [6:0] exp, input int reps);
        vec_t x;
        x.rst = rst; x.en = en; x.flt = flt; x.clr = clr; x.code = code; x.exp = exp;
        for (int r = 0; r < reps; r++) vecs.push_back(x);
    endtask

    task automatic drive_and_check(input vec_t x, input int idx);
        logic [6:0] got, e;
        @(negedge clock);
        reset = x.rst; enable = x.en; fault = x.flt; clr_err = x.clr; pwm = x.code;
        exp_q.push_back(x.exp);
        @(posedge clock);
        #1;
        got = {hs_a, ls_a, hs_b, ls_b, dead_a, dead_b, err_invalid};
        e = exp_q.pop_front();
        check($sformatf("vec%0d", idx), int'(got), int'(e));
    endtask

    initial begin
        int n;
        int hold;
        int off_a, off_b;

        // reset, then first turn-on after a full dead time
        v(1, 1, 0, 0, 2'b00, 7'b0000_11_0, 2);
        v(0, 1, 0, 0, 2'b00, 7'b0000_11_0, 4);
        v(0, 1, 0, 0, 2'b00, 7'b0101_00_0, 3);
        // 00 -> 01: ls_a drops one edge after pwm_q, hs_a after 4 dead clocks
        v(0, 1, 0, 0, 2'b01, 7'b0101_00_0, 1);
        v(0, 1, 0, 0, 2'b01, 7'b0001_10_0, 4);
        // 11 arrives on hs_a's first on-cycle: min-on holds it a second cycle
        v(0, 1, 0, 0, 2'b11, 7'b1001_00_0, 1);
        v(0, 1, 0, 0, 2'b11, 7'b1000_01_0, 1);
        v(0, 1, 0, 0, 2'b11, 7'b0000_11_0, 3);
        v(0, 1, 0, 0, 2'b11, 7'b0010_10_0, 1);
        v(0, 1, 0, 0, 2'b11, 7'b0110_00_0, 1);
        // fault while on, then full dead time on release
        v(0, 1, 1, 0, 2'b11, 7'b0000_11_0, 1);
        v(0, 1, 0, 0, 2'b11, 7'b0000_11_0, 4);
        v(0, 1, 0, 0, 2'b11, 7'b0110_00_0, 1);
        // disable, then fault in the middle of dead time restarts it
        v(0, 0, 0, 0, 2'b11, 7'b0000_11_0, 1);
        v(0, 1, 0, 0, 2'b11, 7'b0000_11_0, 1);
        v(0, 1, 1, 0, 2'b11, 7'b0000_11_0, 1);
        v(0, 1, 0, 0, 2'b11, 7'b0000_11_0, 4);
        v(0, 1, 0, 0, 2'b11, 7'b0110_00_0, 1);
        // invalid code for one clock: flag sets, leg B dead time not shortened by the revert
        v(0, 1, 0, 0, 2'b10, 7'b0110_00_0, 1);
        v(0, 1, 0, 0, 2'b11, 7'b0100_01_1, 4);
        v(0, 1, 0, 0, 2'b11, 7'b0110_00_1, 1);
        v(0, 1, 0, 1, 2'b11, 7'b0110_00_0, 1);
        // clear coincident with a new invalid sample: set wins
        v(0, 1, 0, 0, 2'b10, 7'b0110_00_0, 1);
        v(0, 1, 0, 1, 2'b11, 7'b0100_01_1, 1);
        v(0, 1, 0, 0, 2'b11, 7'b0100_01_1, 3);
        v(0, 1, 0, 0, 2'b11, 7'b0110_00_1, 1);
        v(0, 1, 0, 1, 2'b11, 7'b0110_00_0, 1);
        v(0, 1, 0, 0, 2'b00, 7'b0110_00_0, 1);
        v(0, 1, 0, 0, 2'b00, 7'b0100_01_0, 1);

        for (int i = 0; i < vecs.size(); i++) drive_and_check(vecs[i], i);

        // settle on +1, then fault must drop gates before the next edge
        @(negedge clock);
        pwm = 2'b01; clr_err = 1'b0;
        repeat (14) @(negedge clock);
        check("settled_pos", int'({hs_a, ls_a, hs_b, ls_b}), 4'b1001);
        fault = 1'b1;
        #1;
        check("fault_comb", int'({hs_a, ls_a, hs_b, ls_b}), 4'b0000);
        @(negedge clock);
        fault = 1'b0;
        n = 0;
        while (!(hs_a || ls_a || hs_b || ls_b) && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("fault_release_latency", n, 1 + DEAD_CYCLES);
        check("fault_release_gates", int'({hs_a, ls_a, hs_b, ls_b}), 4'b1001);

        // random stream: no shoot-through, every off gap at least a dead time
        hold = 0; off_a = 0; off_b = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            if (hold == 0) begin
                pwm  = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 8);
            end
            hold--;
            fault   = ($urandom_range(0, 199) == 0);
            clr_err = ($urandom_range(0, 15) == 0);
            @(posedge clock);
            #1;
            check("shoot_a", int'(hs_a && ls_a), 0);
            check("shoot_b", int'(hs_b && ls_b), 0);
            if (!hs_a && !ls_a) off_a++;
            else begin
                if (off_a != 0) check("gap_a", int'(off_a >= DEAD_CYCLES), 1);
                off_a = 0;
            end
            if (!hs_b && !ls_b) off_b++;
            else begin
                if (off_b != 0) check("gap_b", int'(off_b >= DEAD_CYCLES), 1);
                off_b = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsm_bridge_driver.md
Name: dsm_bridge_driver

Overview:
- Consumes the DSM ternary output code (pwm[1:0]: 00 = 0, 01 = +1, 11 = -1) and drives a full H-bridge: leg A and leg B, each with a high-side and a low-side gate.
- Inserts programmable dead time and minimum on-time per leg, so neither leg can shoot through.
- Provides fault/enable shutdown and flags invalid codes.
- Sits directly downstream of the modulator's pwm register, at the chip's gate-driver pins.

Parameters:
- DEAD_CYCLES, 4: clocks with both switches of a leg off between any turn-off and the opposite turn-on; legal range 1..255.
- MIN_ON_CYCLES, 2: minimum clocks a switch stays on before a normal turn-off; legal range 1..255.
- CNT_W, 8: width of the dead-time and min-on counters.

Ports:
- clock  in  1  system clock (same domain as the modulator)
- reset  in  1  synchronous, active-high
- pwm  in  2  ternary code from the modulator: 00 zero, 01 +1, 11 -1, 10 invalid
- enable  in  1  high = bridge may conduct
- fault  in  1  active-high external fault; forces all gates off
- clr_err  in  1  single-cycle pulse; clears err_invalid
- hs_a  out  1  leg A high-side gate
- ls_a  out  1  leg A low-side gate
- hs_b  out  1  leg B high-side gate
- ls_b  out  1  leg B low-side gate
- dead_a  out  1  leg A currently in dead time or OFF
- dead_b  out  1  leg B currently in dead time or OFF
- err_invalid  out  1  sticky flag; set when code 10 is sampled

Behaviour:
- Input stage:
  - pwm is registered once into pwm_q.
  - Leg requests are decoded from pwm_q (1 = high side, 0 = low side):
    - 01 → reqA = 1, reqB = 0
    - 11 → reqA = 0, reqB = 1
    - 00 → reqA = 0, reqB = 0 (low-side freewheel)
    - 10 → treated as 00, and err_invalid is set.
- err_invalid:
  - When clr_err and an invalid sample occur in the same cycle, set wins.
- Per-leg FSM states: OFF, DEAD, LOW_ON, HIGH_ON.
- Gate outputs are registered from state only:
  - hs = (state == HIGH_ON), ls = (state == LOW_ON).
  - Final AND with !fault is combinational, so a fault drops gates in the same cycle.
- OFF:
  - Both gates off.
  - If enable && !fault: go to DEAD and load cnt = DEAD_CYCLES-1.
- DEAD:
  - Both gates off; cnt decrements each clock.
  - When cnt == 0: go to HIGH_ON if req = 1, else LOW_ON, and load mcnt = MIN_ON_CYCLES-1.
  - The side chosen is the one requested at dead-time expiry; a request that reverts mid-dead-time does not shorten or restart the dead time.
- LOW_ON / HIGH_ON:
  - mcnt decrements to 0 and holds there.
  - If req differs from the current side and mcnt == 0: go to DEAD and load cnt = DEAD_CYCLES-1.
  - If req differs and mcnt != 0: the request is held pending and re-evaluated each cycle.
- Global priority, every state:
  - fault || !enable → next state OFF, both legs.
  - This overrides min-on and dead-time counters.
- Latency:
  - A change in pwm sampled at edge t reaches pwm_q at t.
  - The active gate drops at edge t+1 (if min-on is satisfied).
  - The opposite gate rises at edge t+1+DEAD_CYCLES.
  - Gate-off interval is exactly DEAD_CYCLES clocks.
- Reset:
  - pwm_q = 00; both legs OFF; counters = 0.
  - All gates 0; dead_a = dead_b = 1; err_invalid = 0.
  - After reset release with enable = 1, the first turn-on occurs after a full dead time.
- Invariant: hs_x && ls_x is never 1 for either leg in any cycle.
- The two legs are independent. A +1 → -1 transition moves both legs through DEAD simultaneously, so the bridge output passes through 0 for DEAD_CYCLES clocks.

Decomposition:
- Shared package dsm_pkg holds:
  - localparams PWM_ZERO = 2'b00, PWM_POS = 2'b01, PWM_NEG = 2'b11, PWM_INV = 2'b10
  - the leg state encoding
- Natural sub-module: dsm_leg_deadtime, one leg FSM with its counters.
  - Inputs: clock, reset, req, run (= enable && !fault).
  - Outputs: hs, ls, dead.
  - Instantiated twice.
- The top level holds only the input register, code decode, error flag and fault gating.

Test Plan:
- Reset, enable = 1, pwm = 00 → all gates 0 for 1+DEAD_CYCLES clocks after release, then ls_a = ls_b = 1; dead_a/b fall together.
- Hold 00 for 10 clocks, step to 01 → ls_a drops 2 clocks after the pwm change; hs_a rises exactly 4 clocks later; ls_b stays 1 throughout.
- 01 held 1 clock then 11, with MIN_ON_CYCLES = 2 → hs_a held on for at least 2 clocks, then 4 clocks dead on both legs, then ls_a = 1 and hs_b = 1.
- Assert fault mid-DEAD, and separately mid-HIGH_ON → all gates 0 in the same cycle. On fault release, a full 4-clock dead time passes before any gate turns on.
- pwm = 10 for 1 clock → err_invalid = 1 from the next clock and sticky; both legs go low side. clr_err clears it. clr_err coincident with another 10 → flag stays 1.
- Random pwm stream of 10k clocks → assertion that hs && ls is never true on either leg, and every gate-off gap between opposite switches is ≥ DEAD_CYCLES.
